// File: rtl/pattern_tx_pkg.sv
// ---------------------------------------------------------------------------
// pattern_tx_pkg
//
// Purpose:
//   Shared definitions for the pattern transmitter: default parameter values,
//   the FSM state encoding, and a helper that turns the requested length into
//   the number of bits actually sent.
//
// Contents:
//   DEFAULT_WIDTH    default maximum pattern length in bits
//   DEFAULT_CLK_DIV  default clk cycles per bit period
//   LEN_W            width of the len input and of the bit counter
//   state_t          FSM states ST_IDLE / ST_SHIFT / ST_DONE
//   effective_len()  maps len=0 or len>max onto max
// ---------------------------------------------------------------------------
package pattern_tx_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_CLK_DIV = 25_000_000;
    localparam int LEN_W           = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A length of zero, or one longer than the shift register, means
    // "send the whole pattern". Any other value is used as is.
    function automatic logic [LEN_W-1:0] effective_len(
        input logic [LEN_W-1:0] len,
        input int unsigned      max_len
    );
        if (len == '0 || 32'(len) > max_len) begin
            return LEN_W'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/pattern_tx_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//
// Purpose:
//   Bit-period divider. While enabled it counts 0..CLK_DIV-1 and wraps,
//   raising tick for exactly the cycle in which the count is CLK_DIV-1.
//   While disabled the count is held at zero and tick stays low, so every
//   enable starts a fresh, full-length bit period.
//
// Ports:
//   clk   in   system clock, rising edge
//   clr   in   asynchronous active-high reset
//   en    in   count enable; count clears when low
//   tick  out  one-cycle pulse at the end of each bit period
// ---------------------------------------------------------------------------
module tick_gen
    import pattern_tx_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Tick is decoded straight from the registered count so it falls the
    // instant en drops or clr forces the count back to zero.
    assign tick = en && (count_q == LAST);

    // Next count: hold at zero when disabled, wrap after the last cycle of
    // the bit period, otherwise advance by one.
    always_comb begin
        count_d = count_q;
        if (!en) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Divider register with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pattern_tx.sv
// ---------------------------------------------------------------------------
// pattern_tx
//
// Purpose:
//   Serial stimulus generator for a state machine under test. On an accepted
//   start it latches a pattern and a length, shifts the pattern out MSB first
//   on x_out, one bit per CLK_DIV clocks, and at the end of every bit period
//   captures the response bit z_in into resp. A one-cycle done pulse marks
//   the end of the transfer.
//
// Ports:
//   clk      in   system clock, rising edge
//   clr      in   asynchronous active-high reset
//   start    in   transfer request, only looked at in IDLE
//   pattern  in   [WIDTH-1:0] bits to send, MSB first
//   len      in   [4:0] number of bits to send (0 or >WIDTH means WIDTH)
//   z_in     in   response bit from the machine under test
//   x_out    out  serial stimulus bit (0 outside a transfer)
//   tick     out  one-cycle pulse at the end of each bit period
//   busy     out  high while bits are being shifted
//   done     out  one-cycle pulse after the last bit
//   resp     out  [WIDTH-1:0] captured responses, first sample highest
// ---------------------------------------------------------------------------
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             z_in,
    output logic             x_out,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resp
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [LEN_W-1:0] bitcnt_q;
    logic [LEN_W-1:0] bitcnt_d;
    logic [WIDTH-1:0] resp_q;
    logic [WIDTH-1:0] resp_d;
    logic             tick_en;

    // The divider only runs while shifting; leaving SHIFT (including via
    // clr) clears it, so a new transfer always begins at count zero.
    assign tick_en = (state_q == ST_SHIFT);

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .clr  (clr),
        .en   (tick_en),
        .tick (tick)
    );

    // Outputs are decoded from registered state only, so clr takes them to
    // zero immediately without waiting for a clock edge.
    assign busy  = (state_q == ST_SHIFT);
    assign done  = (state_q == ST_DONE);
    assign x_out = (state_q == ST_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
    assign resp  = resp_q;

    // Next-state logic. IDLE loads a new transfer on start. SHIFT advances
    // one bit per tick: the response bit is sampled at the same edge that
    // moves the next stimulus bit to the MSB, and the edge that takes the
    // counter from one to zero ends the transfer. DONE lasts one cycle and
    // ignores start, so a held start re-triggers from the following IDLE.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        resp_d   = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d  = pattern;
                    bitcnt_d = effective_len(len, WIDTH);
                    resp_d   = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    resp_d   = {resp_q[WIDTH-2:0], z_in};
                    shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                    bitcnt_d = bitcnt_q - LEN_W'(1);
                    if (bitcnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. clr abandons any transfer in progress; since the
    // counters and state all return to IDLE values, nothing resumes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            resp_q   <= resp_d;
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_pattern_tx
//
// Purpose:
//   Self-checking bench for pattern_tx with WIDTH=8, CLK_DIV=4. Expected
//   stimulus bits and transfer results are queued when a start is issued and
//   consumed by a monitor as the DUT produces ticks and done pulses.
// ---------------------------------------------------------------------------
module tb_pattern_tx;

   localparam int WIDTH   = 8;
   localparam int CLK_DIV = 4;

   typedef struct {
      logic [WIDTH-1:0] resp;
      int               nbits;
   } xfer_t;

   logic             clk;
   logic             clr;
   logic             start;
   logic [WIDTH-1:0] pattern_in;
   logic [4:0]       len_in;
   logic             z_in;
   logic             x_out;
   logic             tick;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] resp;

   logic             loopback;
   logic             z_const;

   int               checks;
   int               errors;
   int               busy_cnt;
   int               tick_cnt;
   logic             exp_x_q[$];
   xfer_t            exp_xfer_q[$];
   xfer_t            cur;
   int               seen_done;
   int               seen_busy;
   int               tick_seen;

   assign z_in = loopback ? x_out : z_const;

   pattern_tx #(
      .WIDTH   (WIDTH),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .pattern (pattern_in),
      .len     (len_in),
      .z_in    (z_in),
      .x_out   (x_out),
      .tick    (tick),
      .busy    (busy),
      .done    (done),
      .resp    (resp)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports failures.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Number of bits the DUT should send for a requested length.
   function automatic int effLen(input logic [4:0] l);
      if (l == 5'd0 || int'(l) > WIDTH) return WIDTH;
      return int'(l);
   endfunction

   // Reference response: the k sampled bits in order, right-aligned.
   function automatic logic [WIDTH-1:0] modelResp(input logic [WIDTH-1:0] pat, input int k,
                                                  input logic lb, input logic zc);
      logic [WIDTH-1:0] r;
      logic             b;
      r = '0;
      for (int i = 0; i < k; i++) begin
         b = lb ? pat[WIDTH-1-i] : zc;
         r = {r[WIDTH-2:0], b};
      end
      return r;
   endfunction

   // Queue the bit stream and the final result of one transfer.
   task automatic pushExpect(input logic [WIDTH-1:0] pat, input logic [4:0] l,
                             input logic lb, input logic zc);
      xfer_t t;
      int    k;
      k = effLen(l);
      for (int i = 0; i < k; i++) exp_x_q.push_back(pat[WIDTH-1-i]);
      t.resp  = modelResp(pat, k, lb, zc);
      t.nbits = k;
      exp_xfer_q.push_back(t);
   endtask

   // Queue expectations, then present a one-cycle start in IDLE.
   task automatic applyStimulus(input logic [WIDTH-1:0] pat, input logic [4:0] l,
                                input logic lb, input logic zc);
      pushExpect(pat, l, lb, zc);
      @(posedge clk);
      #1;
      loopback   = lb;
      z_const    = zc;
      pattern_in = pat;
      len_in     = l;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
   endtask

   // Bounded wait for the done pulse; returns on the negedge where done=1.
   task automatic waitDone(input string tag);
      int got;
      got = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      checkOutput(tag, got, 1);
   endtask

   // Monitor: x_out must match the head of the bit queue on every busy
   // cycle, each tick retires one bit, and each done retires one transfer
   // whose response, busy length and tick count are compared.
   always @(negedge clk) begin
      if (clr) begin
         busy_cnt = 0;
         tick_cnt = 0;
      end else begin
         if (busy) begin
            busy_cnt++;
            if (exp_x_q.size() == 0) checkOutput("busy_without_bits", busy, 0);
            else checkOutput("x_out_bit", x_out, exp_x_q[0]);
         end
         if (tick) begin
            tick_cnt++;
            if (exp_x_q.size() == 0) checkOutput("unexpected_tick", tick, 0);
            else void'(exp_x_q.pop_front());
         end
         if (done) begin
            if (exp_xfer_q.size() == 0) begin
               checkOutput("unexpected_done", done, 0);
            end else begin
               cur = exp_xfer_q.pop_front();
               checkOutput("resp_at_done", resp, cur.resp);
               checkOutput("busy_cycles", busy_cnt, cur.nbits * CLK_DIV);
               checkOutput("tick_count", tick_cnt, cur.nbits);
            end
            busy_cnt = 0;
            tick_cnt = 0;
         end
      end
   end

   // Directed sequence.
   initial begin
      checks     = 0;
      errors     = 0;
      busy_cnt   = 0;
      tick_cnt   = 0;
      clr        = 1'b1;
      start      = 1'b0;
      pattern_in = '0;
      len_in     = '0;
      loopback   = 1'b0;
      z_const    = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_x_out", x_out, 0);
      checkOutput("rst_tick", tick, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_resp", resp, 0);
      clr = 1'b0;

      // Loopback, full length.
      $display("[TB] loopback 8'hB2 len 8");
      applyStimulus(8'hB2, 5'd8, 1'b1, 1'b0);
      waitDone("done_loopback");
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
      checkOutput("idle_busy", busy, 0);
      repeat (3) @(negedge clk);
      checkOutput("resp_hold", resp, 8'hB2);
      checkOutput("idle_x_out", x_out, 0);
      checkOutput("idle_tick", tick, 0);

      // Short lengths and length boundaries.
      $display("[TB] length variants");
      applyStimulus(8'hE0, 5'd3, 1'b0, 1'b1);
      waitDone("done_len3");
      applyStimulus(8'hE0, 5'd0, 1'b0, 1'b1);
      waitDone("done_len0");
      applyStimulus(8'h80, 5'd1, 1'b1, 1'b0);
      waitDone("done_len1");
      applyStimulus(8'hA5, 5'd5, 1'b1, 1'b0);
      waitDone("done_len5");
      applyStimulus(8'hC3, 5'd20, 1'b1, 1'b0);
      waitDone("done_len20");

      // Starts during a transfer are ignored.
      $display("[TB] ignored starts");
      applyStimulus(8'hB2, 5'd8, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      pattern_in = 8'h00;
      len_in     = 5'd1;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      waitDone("done_ignored");

      // Reset after the third tick.
      $display("[TB] reset mid-transfer");
      applyStimulus(8'hB2, 5'd8, 1'b1, 1'b0);
      tick_seen = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (tick) tick_seen++;
         if (tick_seen == 3) break;
      end
      checkOutput("third_tick_seen", tick_seen, 3);
      @(posedge clk);
      #1;
      checkOutput("resp_before_clr", resp, 8'h05);
      clr = 1'b1;
      #1;
      checkOutput("clr_x_out", x_out, 0);
      checkOutput("clr_tick", tick, 0);
      checkOutput("clr_busy", busy, 0);
      checkOutput("clr_done", done, 0);
      checkOutput("clr_resp", resp, 0);
      exp_x_q.delete();
      exp_xfer_q.delete();
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      seen_done = 0;
      seen_busy = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen_done++;
         if (busy) seen_busy++;
      end
      checkOutput("no_done_after_clr", seen_done, 0);
      checkOutput("no_resume_after_clr", seen_busy, 0);
      applyStimulus(8'h3C, 5'd8, 1'b1, 1'b0);
      waitDone("done_after_clr");

      // Back-to-back with start held high.
      $display("[TB] back-to-back");
      pushExpect(8'hB2, 5'd8, 1'b1, 1'b0);
      pushExpect(8'h5C, 5'd8, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      loopback   = 1'b1;
      pattern_in = 8'hB2;
      len_in     = 5'd8;
      start      = 1'b1;
      @(posedge clk);
      #1;
      pattern_in = 8'h5C;
      waitDone("done_b2b_first");
      @(negedge clk);
      checkOutput("b2b_idle_busy", busy, 0);
      checkOutput("b2b_idle_resp", resp, 8'hB2);
      @(posedge clk);
      #1;
      checkOutput("b2b_restart_busy", busy, 1);
      checkOutput("b2b_resp_cleared", resp, 0);
      start = 1'b0;
      waitDone("done_b2b_second");

      repeat (3) @(negedge clk);
      checkOutput("sb_bits_left", exp_x_q.size(), 0);
      checkOutput("sb_xfers_left", exp_xfer_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
